// File: rtl/frame_scheduler_pkg.sv
// Shared definitions for the frame scheduler: FSM state encodings and the bank
// reset values. Debug readback and the top level both decode state from here.
package frame_scheduler_pkg;

    typedef logic [1:0] frame_state_t;

    localparam frame_state_t S_Idle     = 2'd0;
    localparam frame_state_t S_Render   = 2'd1;
    localparam frame_state_t S_Convert  = 2'd2;
    localparam frame_state_t S_WaitSwap = 2'd3;

    // After reset the converter writes bank 1 while the SNES shows bank 0.
    localparam logic WRITE_BANK_RESET   = 1'b1;
    localparam logic DISPLAY_BANK_RESET = 1'b0;

endpackage

// File: rtl/frame_scheduler_if.sv
// Handshake and status bundle between the frame scheduler (master) and the
// renderer / PPU converter / SNES side (slave).
interface frame_scheduler_if;

    logic        enable;
    logic        render_start_tick;
    logic        render_done_tick;
    logic        convert_start_tick;
    logic        convert_done_tick;
    logic        snes_vblank_tick;
    logic        write_bank;
    logic        display_bank;
    logic        frame_ready;
    logic        busy;
    logic [15:0] frame_count;
    logic        watchdog_fault;

    modport master (
        input  enable,
        input  render_done_tick,
        input  convert_done_tick,
        input  snes_vblank_tick,
        output render_start_tick,
        output convert_start_tick,
        output write_bank,
        output display_bank,
        output frame_ready,
        output busy,
        output frame_count,
        output watchdog_fault
    );

    modport slave (
        output enable,
        output render_done_tick,
        output convert_done_tick,
        output snes_vblank_tick,
        input  render_start_tick,
        input  convert_start_tick,
        input  write_bank,
        input  display_bank,
        input  frame_ready,
        input  busy,
        input  frame_count,
        input  watchdog_fault
    );

endinterface

// File: rtl/frame_watchdog.sv
// Phase timeout counter for the frame scheduler. Cleared by restart, counts
// while run is high, and flags expire once WATCHDOG_CYCLES-1 is reached.
module frame_watchdog #(
    parameter logic [23:0] WATCHDOG_CYCLES = 24'd16_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic run,
    output logic expire
);

    logic [23:0] count_q;
    logic [23:0] count_d;

    // Clear on phase entry, otherwise count every cycle the phase is active.
    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + 24'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A phase that is being restarted this cycle has not timed out.
    assign expire = run && !restart && (count_q == (WATCHDOG_CYCLES - 24'd1));

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: render, then PPU convert, then wait for SNES vblank to
// swap the ping-pong framebuffer banks. Optional hang watchdog is built when
// SRT_FRAME_WATCHDOG_EN is defined.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter logic [23:0] WATCHDOG_CYCLES = 24'd16_000_000
) (
    input  logic                      clock,
    input  logic                      reset,
    frame_scheduler_if.master         bus
);

    frame_state_t state_q, state_d;
    logic         render_start_q, render_start_d;
    logic         convert_start_q, convert_start_d;
    logic         write_bank_q, write_bank_d;
    logic         display_bank_q, display_bank_d;
    logic         frame_ready_q, frame_ready_d;
    logic [15:0]  frame_count_q, frame_count_d;
    logic         fault_q, fault_d;
    logic         wd_restart;
    logic         wd_run;
    logic         wd_expire;

    assign wd_run = (state_q == S_Render) || (state_q == S_Convert);

`ifdef SRT_FRAME_WATCHDOG_EN
    frame_watchdog #(
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
    ) u_frame_watchdog (
        .clock   (clock),
        .reset   (reset),
        .restart (wd_restart),
        .run     (wd_run),
        .expire  (wd_expire)
    );
`else
    logic unused_watchdog;
    assign unused_watchdog = ^{WATCHDOG_CYCLES, wd_restart, wd_run};
    assign wd_expire       = 1'b0;
`endif

    // Next-state and registered-output logic; done ticks outside their
    // matching state fall through the case and are dropped.
    always_comb begin
        state_d         = state_q;
        render_start_d  = 1'b0;
        convert_start_d = 1'b0;
        write_bank_d    = write_bank_q;
        display_bank_d  = display_bank_q;
        frame_ready_d   = frame_ready_q;
        frame_count_d   = frame_count_q;
        fault_d         = fault_q;
        wd_restart      = 1'b0;
        case (state_q)
            S_Idle: begin
                if (bus.enable) begin
                    render_start_d = 1'b1;
                    wd_restart     = 1'b1;
                    state_d        = S_Render;
                end
            end
            S_Render: begin
                if (bus.render_done_tick) begin
                    convert_start_d = 1'b1;
                    wd_restart      = 1'b1;
                    state_d         = S_Convert;
                end else if (wd_expire) begin
                    fault_d = 1'b1;
                    state_d = S_Idle;
                end
            end
            S_Convert: begin
                if (bus.convert_done_tick) begin
                    frame_ready_d = 1'b1;
                    state_d       = S_WaitSwap;
                end else if (wd_expire) begin
                    fault_d = 1'b1;
                    state_d = S_Idle;
                end
            end
            S_WaitSwap: begin
                if (bus.snes_vblank_tick) begin
                    display_bank_d = write_bank_q;
                    write_bank_d   = ~write_bank_q;
                    frame_ready_d  = 1'b0;
                    frame_count_d  = frame_count_q + 16'd1;
                    if (bus.enable) begin
                        render_start_d = 1'b1;
                        wd_restart     = 1'b1;
                        state_d        = S_Render;
                    end else begin
                        state_d = S_Idle;
                    end
                end
            end
            default: state_d = S_Idle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_Idle;
            render_start_q  <= 1'b0;
            convert_start_q <= 1'b0;
            write_bank_q    <= WRITE_BANK_RESET;
            display_bank_q  <= DISPLAY_BANK_RESET;
            frame_ready_q   <= 1'b0;
            frame_count_q   <= '0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            render_start_q  <= render_start_d;
            convert_start_q <= convert_start_d;
            write_bank_q    <= write_bank_d;
            display_bank_q  <= display_bank_d;
            frame_ready_q   <= frame_ready_d;
            frame_count_q   <= frame_count_d;
            fault_q         <= fault_d;
        end
    end

    assign bus.render_start_tick  = render_start_q;
    assign bus.convert_start_tick = convert_start_q;
    assign bus.write_bank         = write_bank_q;
    assign bus.display_bank       = display_bank_q;
    assign bus.frame_ready        = frame_ready_q;
    assign bus.busy               = (state_q != S_Idle);
    assign bus.frame_count        = frame_count_q;
    assign bus.watchdog_fault     = fault_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler. Cycle n means the values visible just
// after the n-th clock edge following reset release.
module tb_frame_scheduler;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   s = 0;
    logic seen_activity;

    frame_scheduler_if bus_if();

    frame_scheduler #(
        .WATCHDOG_CYCLES (24'd100)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " render_start"}, 32'(bus_if.render_start_tick), 32'd0);
        check({tag, " convert_start"}, 32'(bus_if.convert_start_tick), 32'd0);
        check({tag, " write_bank"}, 32'(bus_if.write_bank), 32'd1);
        check({tag, " display_bank"}, 32'(bus_if.display_bank), 32'd0);
        check({tag, " frame_ready"}, 32'(bus_if.frame_ready), 32'd0);
        check({tag, " busy"}, 32'(bus_if.busy), 32'd0);
        check({tag, " frame_count"}, 32'(bus_if.frame_count), 32'd0);
        check({tag, " watchdog_fault"}, 32'(bus_if.watchdog_fault), 32'd0);
    endtask

    initial begin
        bus_if.enable            = 1'b0;
        bus_if.render_done_tick  = 1'b0;
        bus_if.convert_done_tick = 1'b0;
        bus_if.snes_vblank_tick  = 1'b0;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("reset");

        reset         = 1'b0;
        bus_if.enable = 1'b1;
        cyc           = 0;

        // Frame 1 start.
        step();
        check("c1 render_start", 32'(bus_if.render_start_tick), 32'd1);
        check("c1 busy", 32'(bus_if.busy), 32'd1);
        check("c1 write_bank", 32'(bus_if.write_bank), 32'd1);
        check("c1 display_bank", 32'(bus_if.display_bank), 32'd0);
        step();
        check("c2 render_start pulse", 32'(bus_if.render_start_tick), 32'd0);

        // Spurious convert_done and vblank in S_Render.
        run_to(5);
        bus_if.convert_done_tick = 1'b1;
        bus_if.snes_vblank_tick  = 1'b1;
        step();
        bus_if.convert_done_tick = 1'b0;
        bus_if.snes_vblank_tick  = 1'b0;
        check("spur frame_ready", 32'(bus_if.frame_ready), 32'd0);
        check("spur convert_start", 32'(bus_if.convert_start_tick), 32'd0);
        check("spur write_bank", 32'(bus_if.write_bank), 32'd1);
        check("spur frame_count", 32'(bus_if.frame_count), 32'd0);
        check("spur busy", 32'(bus_if.busy), 32'd1);

        // render_done with a simultaneous convert_done: only render acts.
        run_to(10);
        bus_if.render_done_tick  = 1'b1;
        bus_if.convert_done_tick = 1'b1;
        step();
        bus_if.render_done_tick  = 1'b0;
        bus_if.convert_done_tick = 1'b0;
        check("c11 convert_start", 32'(bus_if.convert_start_tick), 32'd1);
        check("c11 frame_ready", 32'(bus_if.frame_ready), 32'd0);
        step();
        check("c12 convert_start pulse", 32'(bus_if.convert_start_tick), 32'd0);

        run_to(50);
        bus_if.convert_done_tick = 1'b1;
        step();
        bus_if.convert_done_tick = 1'b0;
        check("c51 frame_ready", 32'(bus_if.frame_ready), 32'd1);
        check("c51 display_bank", 32'(bus_if.display_bank), 32'd0);

        run_to(80);
        bus_if.snes_vblank_tick = 1'b1;
        step();
        bus_if.snes_vblank_tick = 1'b0;
        check("c81 display_bank", 32'(bus_if.display_bank), 32'd1);
        check("c81 write_bank", 32'(bus_if.write_bank), 32'd0);
        check("c81 frame_count", 32'(bus_if.frame_count), 32'd1);
        check("c81 frame_ready", 32'(bus_if.frame_ready), 32'd0);
        check("c81 render_start", 32'(bus_if.render_start_tick), 32'd1);
        check("c81 busy", 32'(bus_if.busy), 32'd1);

        // Frame 2 with enable dropped during S_Convert.
        run_to(85);
        bus_if.render_done_tick = 1'b1;
        step();
        bus_if.render_done_tick = 1'b0;
        check("c86 convert_start", 32'(bus_if.convert_start_tick), 32'd1);
        run_to(87);
        bus_if.enable = 1'b0;
        run_to(90);
        bus_if.convert_done_tick = 1'b1;
        step();
        bus_if.convert_done_tick = 1'b0;
        check("c91 frame_ready", 32'(bus_if.frame_ready), 32'd1);
        check("c91 busy", 32'(bus_if.busy), 32'd1);
        run_to(95);
        bus_if.snes_vblank_tick = 1'b1;
        step();
        bus_if.snes_vblank_tick = 1'b0;
        check("c96 frame_count", 32'(bus_if.frame_count), 32'd2);
        check("c96 write_bank", 32'(bus_if.write_bank), 32'd1);
        check("c96 display_bank", 32'(bus_if.display_bank), 32'd0);
        check("c96 frame_ready", 32'(bus_if.frame_ready), 32'd0);
        check("c96 render_start", 32'(bus_if.render_start_tick), 32'd0);
        check("c96 busy", 32'(bus_if.busy), 32'd0);
        check("c96 watchdog_fault", 32'(bus_if.watchdog_fault), 32'd0);

        seen_activity = 1'b0;
        repeat (10) begin
            step();
            if (bus_if.render_start_tick || bus_if.busy) seen_activity = 1'b1;
        end
        check("parked idle", 32'(seen_activity), 32'd0);

        // Frame 3.
        bus_if.enable = 1'b1;
        step();
        check("c107 render_start", 32'(bus_if.render_start_tick), 32'd1);
        s = cyc;

`ifdef SRT_FRAME_WATCHDOG_EN
        // No render_done: timeout 100 cycles after the start edge.
        run_to(s + 99);
        check("wd pre fault", 32'(bus_if.watchdog_fault), 32'd0);
        check("wd pre busy", 32'(bus_if.busy), 32'd1);
        step();
        check("wd fault", 32'(bus_if.watchdog_fault), 32'd1);
        check("wd busy", 32'(bus_if.busy), 32'd0);
        check("wd write_bank", 32'(bus_if.write_bank), 32'd1);
        check("wd display_bank", 32'(bus_if.display_bank), 32'd0);
        check("wd frame_ready", 32'(bus_if.frame_ready), 32'd0);
        check("wd frame_count", 32'(bus_if.frame_count), 32'd2);
        step();
        check("wd restart render", 32'(bus_if.render_start_tick), 32'd1);
        check("wd fault sticky", 32'(bus_if.watchdog_fault), 32'd1);
        s = cyc;
`endif

        run_to(s + 3);
        bus_if.render_done_tick = 1'b1;
        step();
        bus_if.render_done_tick = 1'b0;
        check("f3 convert_start", 32'(bus_if.convert_start_tick), 32'd1);
        run_to(s + 6);
        bus_if.convert_done_tick = 1'b1;
        step();
        bus_if.convert_done_tick = 1'b0;
        check("f3 frame_ready", 32'(bus_if.frame_ready), 32'd1);

        // Reset mid-S_WaitSwap with a vblank pending: nothing is committed.
        run_to(s + 9);
        bus_if.snes_vblank_tick = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async reset");
        bus_if.snes_vblank_tick = 1'b0;
        step();
        step();
        check_reset_values("held reset");
        reset         = 1'b0;
        bus_if.enable = 1'b0;
        step();
        check_reset_values("post reset idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
